// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus layouts, load op codes, reset level.
package mem_stage_pkg;
  localparam int   PC_INST_W    = 64;
  localparam int   EXE_TO_MEM_W = 41;
  localparam int   MEM_TO_WB_W  = 38;
  localparam logic RST_ENABLE   = 1'b0;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_H    = 3'd2,
    LD_W    = 3'd3,
    LD_BU   = 3'd4,
    LD_HU   = 3'd5,
    LD_RSV6 = 3'd6,
    LD_RSV7 = 3'd7
  } load_op_e;

  // {load_op[40:38], reg_we[37], waddr[36:32], alu_result[31:0]}
  typedef struct packed {
    load_op_e    load_op;
    logic        reg_we;
    logic [4:0]  waddr;
    logic [31:0] alu_result;
  } exe_to_mem_t;

  // {we[37], waddr[36:32], wdata[31:0]}
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } mem_to_wb_t;

  function automatic logic is_load(load_op_e op);
    return (op >= LD_B) && (op <= LD_HU);
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// EXE->MEM->WB handshake, data-SRAM response and writeback buses seen by the MEM stage.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int PC_INST_W    = mem_stage_pkg::PC_INST_W,
  parameter int EXE_TO_MEM_W = mem_stage_pkg::EXE_TO_MEM_W,
  parameter int MEM_TO_WB_W  = mem_stage_pkg::MEM_TO_WB_W
);
  logic                    exe_to_mem_valid_i;
  logic                    mem_allowin_o;
  logic [PC_INST_W-1:0]    pc_inst_ibus;
  logic [EXE_TO_MEM_W-1:0] exe_to_ibus;
  logic [31:0]             data_sram_rdata_i;
  logic                    data_sram_data_ok_i;
  logic                    wb_allowin_i;
  logic                    mem_to_wb_valid_o;
  logic [PC_INST_W-1:0]    pc_inst_obus;
  logic [MEM_TO_WB_W-1:0]  mem_to_wb_obus;

  modport slave (
    input  exe_to_mem_valid_i, pc_inst_ibus, exe_to_ibus,
           data_sram_rdata_i, data_sram_data_ok_i, wb_allowin_i,
    output mem_allowin_o, mem_to_wb_valid_o, pc_inst_obus, mem_to_wb_obus
  );

  modport master (
    output exe_to_mem_valid_i, pc_inst_ibus, exe_to_ibus,
           data_sram_rdata_i, data_sram_data_ok_i, wb_allowin_i,
    input  mem_allowin_o, mem_to_wb_valid_o, pc_inst_obus, mem_to_wb_obus
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a 32-bit load word and sign/zero extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  load_op_e    load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] ld_src,
  output logic [31:0] aligned
);
  logic [31:0] shifted;
  logic [7:0]  b8;
  logic [15:0] h16;

  assign shifted = ld_src >> {addr, 3'b000};
  assign b8      = shifted[7:0];
  // addr[0] is ignored for halves; misaligned accesses are trapped upstream
  assign h16     = addr[1] ? ld_src[31:16] : ld_src[15:0];

  always_comb begin
    aligned = ld_src;
    case (load_op)
      LD_B:    aligned = {{24{b8[7]}}, b8};
      LD_BU:   aligned = {24'd0, b8};
      LD_H:    aligned = {{16{h16[15]}}, h16};
      LD_HU:   aligned = {16'd0, h16};
      default: aligned = ld_src;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE result, waits for load data, drives the WB bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_INST_W = mem_stage_pkg::PC_INST_W
)(
  input  logic      clk,
  input  logic      rst_n,
  mem_stage_if.slave io
);
  logic                 mem_valid;
  logic [PC_INST_W-1:0] pc_inst_r;
  exe_to_mem_t          exe_r;
  logic [31:0]          rdata_buf;
  logic                 rdata_buf_valid;

  logic        ld;
  logic        ready_go;
  logic        allowin;
  logic [31:0] ld_src;
  logic [31:0] aligned;
  mem_to_wb_t  wb;

  assign ld       = is_load(exe_r.load_op);
  assign ready_go = !ld | rdata_buf_valid | io.data_sram_data_ok_i;
  assign allowin  = !mem_valid | (ready_go & io.wb_allowin_i);
  assign ld_src   = rdata_buf_valid ? rdata_buf : io.data_sram_rdata_i;

  load_align u_align (
    .load_op (exe_r.load_op),
    .addr    (exe_r.alu_result[1:0]),
    .ld_src  (ld_src),
    .aligned (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst_n == RST_ENABLE) begin
      mem_valid       <= 1'b0;
      pc_inst_r       <= '0;
      exe_r           <= '0;
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else if (allowin) begin
      mem_valid       <= io.exe_to_mem_valid_i;
      rdata_buf_valid <= 1'b0;
      if (io.exe_to_mem_valid_i) begin
        pc_inst_r <= io.pc_inst_ibus;
        exe_r     <= exe_to_mem_t'(io.exe_to_ibus);
      end
    end else if (mem_valid && ld && !rdata_buf_valid && io.data_sram_data_ok_i) begin
      // WB is stalled: capture the one-shot response so the output stays stable
      rdata_buf       <= io.data_sram_rdata_i;
      rdata_buf_valid <= 1'b1;
    end
  end

  always_comb begin
    wb.we    = exe_r.reg_we & mem_valid;
    wb.waddr = exe_r.waddr;
    wb.wdata = ld ? aligned : exe_r.alu_result;
  end

  assign io.mem_allowin_o     = allowin;
  assign io.mem_to_wb_valid_o = mem_valid & ready_go;
  assign io.pc_inst_obus      = pc_inst_r;
  assign io.mem_to_wb_obus    = wb;
endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

  typedef struct {
    logic [63:0] pc_inst;
    logic [2:0]  op;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] rdata;
    int          delay;
  } txn_t;

  typedef struct {
    logic [63:0] pc_inst;
    logic [37:0] obus;
  } exp_t;

  txn_t txq[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic op_is_load(logic [2:0] op);
    return op >= 3'd1 && op <= 3'd5;
  endfunction

  // Reference result computed from the load rules with plain arithmetic.
  function automatic logic [37:0] ref_obus(txn_t t);
    logic [31:0] b, h, d;
    b = (t.rdata >> ((t.alu % 4) * 8)) % 256;
    h = (t.alu % 4 >= 2) ? (t.rdata >> 16) : (t.rdata % 65536);
    case (t.op)
      3'd1:    d = (b >= 128) ? b - 32'd256 : b;
      3'd2:    d = (h >= 32768) ? h - 32'd65536 : h;
      3'd3:    d = t.rdata;
      3'd4:    d = b;
      3'd5:    d = h;
      default: d = t.alu;
    endcase
    return {t.we, t.waddr, d};
  endfunction

  function automatic txn_t mk(logic [2:0] op, logic we, logic [4:0] wa, logic [31:0] alu,
                              logic [31:0] rd, int dly);
    txn_t t;
    t.pc_inst = {$urandom, $urandom};
    t.op = op; t.we = we; t.waddr = wa; t.alu = alu; t.rdata = rd; t.delay = dly;
    return t;
  endfunction

  // Monitor: pops the scoreboard on every handoff and checks stall stability.
  initial begin
    logic        prev_stall = 1'b0;
    logic [63:0] prev_pc;
    logic [37:0] prev_ob;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev_stall = 1'b0; continue; end
      if (prev_stall) begin
        check("stall_valid", bus.mem_to_wb_valid_o, 1'b1);
        check("stall_obus", bus.mem_to_wb_obus, prev_ob);
        check("stall_pc", bus.pc_inst_obus, prev_pc);
      end
      if (bus.mem_to_wb_valid_o && bus.wb_allowin_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handoff", bus.mem_to_wb_obus, 38'h0);
        end else begin
          e = exp_q.pop_front();
          check("wb_obus", bus.mem_to_wb_obus, e.obus);
          check("wb_pc", bus.pc_inst_obus, e.pc_inst);
        end
      end
      prev_stall = bus.mem_to_wb_valid_o && !bus.wb_allowin_i;
      prev_pc    = bus.pc_inst_obus;
      prev_ob    = bus.mem_to_wb_obus;
    end
  end

  // Stimulus: drives EXE, SRAM and WB sides and tracks occupancy at transaction level.
  initial begin
    txn_t cur_in, mem_t;
    logic exe_v = 1'b0, occ = 1'b0, occ_load = 1'b0, resp = 1'b0;
    logic give, ready, exp_allow;
    int   delay = 0, cyc = 0;

    bus.exe_to_mem_valid_i  = 1'b0;
    bus.pc_inst_ibus        = '0;
    bus.exe_to_ibus         = '0;
    bus.data_sram_rdata_i   = '0;
    bus.data_sram_data_ok_i = 1'b0;
    bus.wb_allowin_i        = 1'b1;

    txq.push_back(mk(3'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 0));
    txq.push_back(mk(3'd1, 1'b1, 5'd7, 32'h1000_0003, 32'h80AA_BBCC, 0));
    txq.push_back(mk(3'd4, 1'b1, 5'd8, 32'h1000_0003, 32'h80AA_BBCC, 0));
    txq.push_back(mk(3'd5, 1'b1, 5'd9, 32'h1000_0002, 32'h80AA_BBCC, 3));
    txq.push_back(mk(3'd3, 1'b1, 5'd10, 32'h1000_0000, 32'h80AA_BBCC, 0));
    for (int i = 0; i < 150; i++)
      txq.push_back(mk(3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom),
                       $urandom, $urandom, $urandom_range(0, 3)));

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.mem_to_wb_valid_o, 1'b0);
    check("rst_allowin", bus.mem_allowin_o, 1'b1);
    check("rst_pc", bus.pc_inst_obus, 64'h0);
    check("rst_obus", bus.mem_to_wb_obus, 38'h0);
    rst_n = 1'b1;

    while ((txq.size() > 0 || exe_v || occ) && cyc < 20000) begin
      @(negedge clk); cyc++;
      bus.wb_allowin_i = ($urandom_range(0, 9) < 7);
      if (!exe_v && txq.size() > 0 && $urandom_range(0, 3) != 0) begin
        cur_in = txq.pop_front();
        exe_v  = 1'b1;
      end
      bus.exe_to_mem_valid_i = exe_v;
      bus.pc_inst_ibus = exe_v ? cur_in.pc_inst : {$urandom, $urandom};
      bus.exe_to_ibus  = exe_v ? {cur_in.op, cur_in.we, cur_in.waddr, cur_in.alu}
                               : {9'($urandom), 32'($urandom)};
      give = occ && occ_load && !resp && delay == 0;
      if (give) begin
        bus.data_sram_data_ok_i = 1'b1;
        bus.data_sram_rdata_i   = mem_t.rdata;
      end else begin
        bus.data_sram_rdata_i   = $urandom;
        bus.data_sram_data_ok_i = (!(occ && occ_load) || resp) ? ($urandom_range(0, 4) == 0) : 1'b0;
      end
      #1;
      ready     = !(occ && occ_load) || resp || give;
      exp_allow = !occ || (ready && bus.wb_allowin_i);
      check("allowin", bus.mem_allowin_o, exp_allow);
      check("valid", bus.mem_to_wb_valid_o, occ && ready);
      if (give) resp = 1'b1;
      else if (occ && occ_load && !resp) delay--;
      if (exp_allow) begin
        occ = exe_v;
        if (exe_v) begin
          mem_t    = cur_in;
          occ_load = op_is_load(cur_in.op);
          resp     = 1'b0;
          delay    = cur_in.delay;
          exp_q.push_back('{pc_inst: cur_in.pc_inst, obus: ref_obus(cur_in)});
          exe_v = 1'b0;
        end
      end
    end
    if (cyc >= 20000) check("timeout", 1'b1, 1'b0);

    // Reset while a load waits for data, then a stray response for it.
    @(negedge clk);
    bus.data_sram_data_ok_i = 1'b0;
    bus.wb_allowin_i        = 1'b1;
    bus.exe_to_mem_valid_i  = 1'b1;
    bus.pc_inst_ibus        = 64'hABCD_0000_1111_2222;
    bus.exe_to_ibus         = {3'd3, 1'b1, 5'd3, 32'h2000_0000};
    #1 check("rl_accept", bus.mem_allowin_o, 1'b1);
    @(negedge clk);
    bus.exe_to_mem_valid_i = 1'b0;
    #1;
    check("rl_wait_valid", bus.mem_to_wb_valid_o, 1'b0);
    check("rl_wait_allowin", bus.mem_allowin_o, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.data_sram_data_ok_i = 1'b1;
    bus.data_sram_rdata_i   = 32'hDEAD_BEEF;
    #1;
    check("rl_stray_valid", bus.mem_to_wb_valid_o, 1'b0);
    check("rl_allowin", bus.mem_allowin_o, 1'b1);
    check("rl_pc", bus.pc_inst_obus, 64'h0);
    check("rl_obus", bus.mem_to_wb_obus, 38'h0);
    @(negedge clk);
    bus.data_sram_data_ok_i = 1'b0;
    #1 check("rl_after_valid", bus.mem_to_wb_valid_o, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
